// File: rtl/instr_fetch_unit.sv
`default_nettype none
// instr_fetch_unit: holds the PC, fetches one instruction word per req/ack handshake
// and computes the next PC from the decoder branch/jump controls when the word retires.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr,
  output logic [5:0]             opcode,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   beq,
  input  logic                   bne,
  input  logic                   jump,
  input  logic                   zero,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [31:0]            C_RESET_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_pc;
  logic [31:0]            r_instr;
  logic                   r_req;
  logic                   r_valid;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic        w_br_taken;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_taken = (beq & ~bne & zero) | (bne & ~beq & ~zero);

  // Jump is tested first so unknown branch controls cannot leak into the PC.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump) begin
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (w_br_taken) begin
      w_next_pc = w_pc_plus4 + w_br_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= C_RESET_PC;
      r_instr <= 32'h0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (r_state == S_FETCH) begin
      // First cycle out of reset only raises the request; an ack is honoured once req is up.
      if (!r_req) begin
        r_req <= 1'b1;
      end else if (imem_ack) begin
        r_instr <= imem_rdata;
        r_req   <= 1'b0;
        r_valid <= 1'b1;
        r_state <= S_HOLD;
      end
    end else begin
      if (instr_ready) begin
        r_pc    <= w_next_pc;
        r_valid <= 1'b0;
        r_req   <= 1'b1;
        r_count <= r_count + C_CNT_ONE;
        r_state <= S_FETCH;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// tb_instr_fetch_unit: directed stimulus with a transaction-level reference model and
// a per-cycle compare process, plus literal checks at the key points of each scenario.
module tb_instr_fetch_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          instr_ready = 1'b0;
  logic          beq = 1'b0;
  logic          bne = 1'b0;
  logic          jump = 1'b0;
  logic          zero = 1'b0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   instr;
  logic [5:0]    opcode;
  logic          instr_valid;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0003), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .beq(beq), .bne(bne), .jump(jump), .zero(zero),
    .pc(pc), .pc_plus4(pc_plus4), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next PC straight from the branch rules using signed integer arithmetic.
  function automatic logic [31:0] f_next(input logic [31:0] cur, input logic [31:0] ins,
                                         input logic b, input logic n, input logic j, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j === 1'b1) return {seq[31:28], ins[25:0], 2'b00};
    off = 4 * int'($signed(ins[15:0]));
    if ((b !== n) && (z === b)) return seq + 32'(off);
    return seq;
  endfunction

  logic [31:0]   m_pc = 32'h0;
  logic [31:0]   m_instr = 32'h0;
  logic          m_have = 1'b0;
  logic          m_asking = 1'b0;
  logic [CW-1:0] m_count = '0;

  // Transaction model: a word is either held awaiting retire, or being requested.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc     <= 32'h0;
      m_instr  <= 32'h0;
      m_have   <= 1'b0;
      m_asking <= 1'b0;
      m_count  <= '0;
    end else if (m_have) begin
      if (instr_ready) begin
        m_pc     <= f_next(m_pc, m_instr, beq, bne, jump, zero);
        m_have   <= 1'b0;
        m_asking <= 1'b1;
        m_count  <= m_count + 1'b1;
      end
    end else if (m_asking && imem_ack) begin
      m_instr  <= imem_rdata;
      m_have   <= 1'b1;
      m_asking <= 1'b0;
    end else begin
      m_asking <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("req",      32'(imem_req),    32'(m_asking));
    chk("addr",     imem_addr,        m_pc);
    chk("instr",    instr,            m_instr);
    chk("opcode",   32'(opcode),      32'(m_instr[31:26]));
    chk("valid",    32'(instr_valid), 32'(m_have));
    chk("pc",       pc,               m_pc);
    chk("pc_plus4", pc_plus4,         m_pc + 32'd4);
    chk("count",    32'(instr_count), 32'(m_count));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a request (spurious ready asserted meanwhile), then acks after dly cycles.
  task automatic fetch(input logic [31:0] w, input int dly);
    int n = 0;
    instr_ready = 1'b1;
    while (!imem_req && n < 10) begin
      tick();
      n++;
    end
    if (!imem_req) chk("fetch_req_timeout", 32'(imem_req), 32'h1);
    repeat (dly) tick();
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = w;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("fetched_valid", 32'(instr_valid), 32'h1);
    chk("fetched_instr", instr, w);
  endtask

  // One spurious ack cycle in HOLD, then retire with the given controls.
  task automatic retire(input logic b, input logic n, input logic j, input logic z,
                        input logic [31:0] exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    beq = b; bne = n; jump = j; zero = z;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    beq = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
    chk("retire_pc",    pc,                exp_pc);
    chk("bubble_valid", 32'(instr_valid),  32'h0);
    chk("bubble_req",   32'(imem_req),     32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk("rst_pc",    pc,                32'h0);
    chk("rst_req",   32'(imem_req),     32'h0);
    chk("rst_valid", 32'(instr_valid),  32'h0);
    chk("rst_instr", instr,             32'h0);
    chk("rst_count", 32'(instr_count),  32'h0);
    rst_n = 1'b1;
    tick();
    chk("req_rise", 32'(imem_req), 32'h1);
    chk("req_addr", imem_addr,     32'h0);
    fetch(32'h2008_0005, 2);
    chk("first_opcode", 32'(opcode),   32'h08);
    chk("first_req",    32'(imem_req), 32'h0);

    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    fetch(32'h0123_4567, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    fetch(32'h0000_0000, 1);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
    chk("count_3", 32'(instr_count), 32'h3);
    fetch(32'h0000_0000, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010);

    fetch(32'h1000_0003, 1);
    retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014);
    fetch(32'h1400_FFFE, 0);
    retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
    fetch(32'h1000_0003, 0);
    retire(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
    fetch(32'h1400_FFFE, 0);
    retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_001C);
    fetch(32'h1000_0003, 0);
    retire(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020);
    fetch(32'h1000_FFF6, 0);
    retire(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch(32'h1400_8000, 0);
    retire(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFE_0000);
    fetch(32'h0800_0000, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_0000);
    fetch(32'h0800_0100, 0);
    retire(1'bx, 1'bx, 1'b1, 1'bx, 32'hF000_0400);
    fetch(32'h1400_0010, 0);
    retire(1'b0, 1'b1, 1'b0, 1'b1, 32'hF000_0404);
    fetch(32'h0000_0000, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'hF000_0408);
    fetch(32'h1000_0020, 0);
    retire(1'b1, 1'b0, 1'b0, 1'b0, 32'hF000_040C);
    chk("count_wrap", 32'(instr_count), 32'h0);

    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req",   32'(imem_req),    32'h0);
    chk("async_pc",    pc,               32'h0);
    chk("async_count", 32'(instr_count), 32'h0);
    chk("async_valid", 32'(instr_valid), 32'h0);
    tick();
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", 32'(instr_valid), 32'h0);
    chk("refetch_req",    32'(imem_req),    32'h1);
    chk("refetch_addr",   imem_addr,        32'h0);
    fetch(32'h2008_0005, 1);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    chk("count_after_rst", 32'(instr_count), 32'h1);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
